// File: rtl/io_tile_top_param.sv
// ============================================================================
// io_tile_top_param
//   Configurable IO tile: serial shadow config chain with commit, routing
//   pads to interconnect and interconnect to pads (optionally registered).
//   Revision: 1.0
// ============================================================================
`default_nettype none

module io_tile_top_param #(
    parameter int IO_WIDTH = 4,
    parameter int IC_WIDTH = 6
) (
    input  logic                config_clock,
    input  logic                config_reset,
    input  logic                config_in,
    input  logic                config_enable,
    input  logic                config_commit,
    output logic                config_out,
    output logic                config_ready,
    output logic                config_active,
    input  logic [IO_WIDTH-1:0] data_from_io,
    output logic [IO_WIDTH-1:0] data_to_io,
    input  logic [IC_WIDTH-1:0] data_from_ic,
    output logic [IC_WIDTH-1:0] data_to_ic
);

    localparam int SEL_IC       = (IC_WIDTH > 1) ? $clog2(IC_WIDTH) : 1;
    localparam int SEL_IO       = (IO_WIDTH > 1) ? $clog2(IO_WIDTH) : 1;
    localparam int CONFIG_WIDTH = IO_WIDTH * (SEL_IC + 1) + IC_WIDTH * SEL_IO;
    localparam int IC_SEL_BASE  = IO_WIDTH * SEL_IC;
    localparam int MODE_BASE    = IO_WIDTH * SEL_IC + IC_WIDTH * SEL_IO;
    localparam int CNT_W        = $clog2(CONFIG_WIDTH + 1);
    localparam int IC_PAD       = 2 ** SEL_IC;
    localparam int IO_PAD       = 2 ** SEL_IO;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CONFIG_WIDTH);

    logic [CONFIG_WIDTH-1:0] shadow;
    logic [CONFIG_WIDTH-1:0] active;
    logic [CNT_W-1:0]        count;
    logic [IO_WIDTH-1:0]     io_reg;
    logic                    active_flag;
    logic [IO_WIDTH-1:0]     io_mux;
    logic [IC_PAD-1:0]       ic_pad;
    logic [IO_PAD-1:0]       io_pad;
    logic                    commit_ok;

    // Zero-extending the sources to a power of two makes any
    // out-of-range select read a constant 0.
    assign ic_pad = IC_PAD'(data_from_ic);
    assign io_pad = IO_PAD'(data_from_io);

    assign config_out    = shadow[CONFIG_WIDTH-1];
    assign config_ready  = (count == CNT_MAX);
    assign config_active = active_flag;
    assign commit_ok     = config_commit && config_ready;

    always_ff @(posedge config_clock) begin
        if (config_reset) begin
            shadow      <= '0;
            active      <= '0;
            count       <= '0;
            io_reg      <= '0;
            active_flag <= 1'b0;
        end else begin
            if (config_enable) begin
                shadow <= {shadow[CONFIG_WIDTH-2:0], config_in};
            end
            if (commit_ok) begin
                active      <= shadow;
                active_flag <= 1'b1;
                count       <= config_enable ? CNT_W'(1) : '0;
            end else if (config_enable && (count != CNT_MAX)) begin
                count <= count + 1'b1;
            end
            io_reg <= io_mux;
        end
    end

    for (genvar i = 0; i < IO_WIDTH; i++) begin : g_to_io
        logic [SEL_IC-1:0] sel;
        assign sel           = active[i*SEL_IC +: SEL_IC];
        assign io_mux[i]     = ic_pad[sel];
        assign data_to_io[i] = active_flag &
                               (active[MODE_BASE+i] ? io_reg[i] : io_mux[i]);
    end

    for (genvar j = 0; j < IC_WIDTH; j++) begin : g_to_ic
        logic [SEL_IO-1:0] sel;
        assign sel           = active[IC_SEL_BASE + j*SEL_IO +: SEL_IO];
        assign data_to_ic[j] = active_flag & io_pad[sel];
    end

endmodule

`default_nettype wire

// File: tb/tb_io_tile_top_param.sv
// ============================================================================
// tb_io_tile_top_param
//   Scoreboard bench for io_tile_top_param against a queue-based chain model.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_io_tile_top_param;

    localparam int IO_W = 4;
    localparam int IC_W = 6;
    localparam int SIC  = 3;
    localparam int SIO  = 2;
    localparam int CW   = 28;
    localparam int MB   = IO_W * SIC + IC_W * SIO;

    logic            clk = 1'b0;
    logic            rst, en, cin, commit;
    logic [IO_W-1:0] from_io;
    logic [IC_W-1:0] from_ic;
    logic            cout, ready, cact_o;
    logic [IO_W-1:0] to_io;
    logic [IC_W-1:0] to_ic;

    always #5 clk = ~clk;

    io_tile_top_param #(.IO_WIDTH(IO_W), .IC_WIDTH(IC_W)) dut (
        .config_clock (clk),
        .config_reset (rst),
        .config_in    (cin),
        .config_enable(en),
        .config_commit(commit),
        .config_out   (cout),
        .config_ready (ready),
        .config_active(cact_o),
        .data_from_io (from_io),
        .data_to_io   (to_io),
        .data_from_ic (from_ic),
        .data_to_ic   (to_ic)
    );

    typedef struct {
        logic            cout;
        logic            ready;
        logic            act;
        logic [IO_W-1:0] to_io;
        logic [IC_W-1:0] to_ic;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: chain as a bit queue, front = oldest bit = config_out.
    bit sq[$];
    int cnt;
    bit act_m[CW];
    bit cact;
    bit ioreg[IO_W];
    bit mvalid = 1'b0;

    function automatic int field(int base, int w);
        int v = 0;
        for (int b = 0; b < w; b++) v += int'(act_m[base+b]) << b;
        return v;
    endfunction

    function automatic bit mux_io(int i);
        int s = field(i * SIC, SIC);
        return (s < IC_W) ? from_ic[s] : 1'b0;
    endfunction

    function automatic bit mux_ic(int j);
        int s = field(IO_W * SIC + j * SIO, SIO);
        return (s < IO_W) ? from_io[s] : 1'b0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("config_out",    32'(cout),   32'(e.cout));
            chk("config_ready",  32'(ready),  32'(e.ready));
            chk("config_active", 32'(cact_o), 32'(e.act));
            chk("data_to_io",    32'(to_io),  32'(e.to_io));
            chk("data_to_ic",    32'(to_ic),  32'(e.to_ic));
        end
    end

    task automatic cycle(input bit r, input bit e, input bit d, input bit c,
                         input logic [IO_W-1:0] fio, input logic [IC_W-1:0] fic);
        exp_t x;
        bit   nio[IO_W];
        bit   acc;
        rst = r; en = e; cin = d; commit = c; from_io = fio; from_ic = fic;
        if (mvalid) begin
            x.cout  = sq[0];
            x.ready = (cnt == CW);
            x.act   = cact;
            for (int i = 0; i < IO_W; i++)
                x.to_io[i] = cact & (act_m[MB+i] ? ioreg[i] : mux_io(i));
            for (int j = 0; j < IC_W; j++)
                x.to_ic[j] = cact & mux_ic(j);
            exp_q.push_back(x);
        end
        @(posedge clk);
        if (r) begin
            sq.delete();
            repeat (CW) sq.push_back(1'b0);
            cnt = 0;
            foreach (act_m[k]) act_m[k] = 1'b0;
            foreach (ioreg[k]) ioreg[k] = 1'b0;
            cact   = 1'b0;
            mvalid = 1'b1;
        end else begin
            for (int i = 0; i < IO_W; i++) nio[i] = mux_io(i);
            acc = c && (cnt == CW);
            if (acc) begin
                for (int k = 0; k < CW; k++) act_m[k] = sq[CW-1-k];
                cact = 1'b1;
                cnt  = e ? 1 : 0;
            end else if (e && cnt < CW) begin
                cnt++;
            end
            if (e) begin
                void'(sq.pop_front());
                sq.push_back(d);
            end
            ioreg = nio;
        end
        #1;
    endtask

    task automatic rcycle(input bit r, input bit e, input bit d, input bit c);
        cycle(r, e, d, c, IO_W'($urandom), IC_W'($urandom));
    endtask

    task automatic load_word(input logic [CW-1:0] w);
        for (int k = CW - 1; k >= 0; k--) rcycle(1'b0, 1'b1, w[k], 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CW-1:0] w;
        // Reset dominates shift enable
        rcycle(1'b1, 1'b1, 1'b1, 1'b1);
        rcycle(1'b0, 1'b0, 1'b0, 1'b0);
        // 28 ones then 28 zeros; ready saturates
        repeat (CW) rcycle(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (CW + 2) rcycle(1'b0, 1'b1, 1'b0, 1'b0);
        // io0 sel=5 comb, ic0 sel=2
        w = '0; w[2:0] = 3'd5; w[13:12] = 2'd2;
        load_word(w);
        rcycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 6'b100000);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 6'b011111);
        // io0 sel=7 (out of range)
        w[2:0] = 3'd7;
        load_word(w);
        rcycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'b1011, 6'b111111);
        // io1 sel=0 registered
        w = '0; w[25] = 1'b1;
        load_word(w);
        rcycle(1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++)
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, IC_W'(k & 1));
        // Commit after 27 shifts is ignored; then commit alongside a shift
        rcycle(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (CW - 1) rcycle(1'b0, 1'b1, 1'($urandom), 1'b0);
        rcycle(1'b0, 1'b0, 1'b0, 1'b1);
        rcycle(1'b0, 1'b1, 1'($urandom), 1'b0);
        rcycle(1'b0, 1'b1, 1'($urandom), 1'b1);
        repeat (3) rcycle(1'b0, 1'b0, 1'b0, 1'b0);
        // Reset the cycle after a commit
        repeat (CW) rcycle(1'b0, 1'b1, 1'($urandom), 1'b0);
        rcycle(1'b0, 1'b0, 1'b0, 1'b1);
        rcycle(1'b1, 1'b1, 1'b1, 1'b1);
        repeat (2) rcycle(1'b0, 1'b0, 1'b0, 1'b0);
        // Random traffic
        for (int n = 0; n < 3000; n++)
            rcycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 8),
                   1'($urandom), ($urandom_range(0, 7) == 0));
        rcycle(1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d entries left expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/io_tile_top_param.md
IO_TILE_TOP_PARAM -- requirements
Module: io_tile_top_param

Interface
REQ-001 SHALL have parameter IO_WIDTH, default 4: number of IO pins.
REQ-002 SHALL have parameter IC_WIDTH, default 6: number of interconnect tracks.
REQ-003 SHALL derive these localparams:
- SEL_IC = max(1, clog2(IC_WIDTH))
- SEL_IO = max(1, clog2(IO_WIDTH))
- CONFIG_WIDTH = IO_WIDTH*(SEL_IC+1) + IC_WIDTH*SEL_IO (28 at defaults).
REQ-004 config_clock  input  1  single clock for all state.
REQ-005 config_reset  input  1  synchronous, active-high reset.
REQ-006 config_in  input  1  serial config bit.
REQ-007 config_enable  input  1  shift enable.
REQ-008 config_commit  input  1  request copy of shadow chain into active config.
REQ-009 config_out  output  1  serial chain output.
REQ-010 config_ready  output  1  exactly CONFIG_WIDTH bits shifted since last commit/reset.
REQ-011 config_active  output  1  at least one commit accepted since reset.
REQ-012 data_from_io  input  IO_WIDTH  pad inputs.
REQ-013 data_to_io  output  IO_WIDTH  pad outputs.
REQ-014 data_from_ic  input  IC_WIDTH  interconnect inputs.
REQ-015 data_to_ic  output  IC_WIDTH  interconnect outputs.

Function
REQ-016 SHALL shift on each config_clock edge with config_enable=1: shadow <= {shadow[CONFIG_WIDTH-2:0], config_in}; config_out = shadow[CONFIG_WIDTH-1], combinational from the register.
REQ-017 SHALL count enabled shifts in a counter that saturates at CONFIG_WIDTH; config_ready = (count == CONFIG_WIDTH), registered-state derived.
REQ-018 Commit is accepted only when config_commit=1 and config_ready=1 in the same cycle. On acceptance, next edge:
- active <= shadow (pre-shift value)
- config_active <= 1
- count <= 0, or 1 if config_enable=1 in the same cycle.
REQ-019 SHALL ignore commit while config_ready=0; active, config_active and count are unchanged, and any enabled shift still occurs.
REQ-020 SHALL leave shadow unchanged by commit; shadow changes only by shifting or reset.
REQ-021 Active config layout:
- bits [i*SEL_IC +: SEL_IC]: source select for data_to_io[i], indexing data_from_ic.
- bits [IO_WIDTH*SEL_IC + j*SEL_IO +: SEL_IO]: source select for data_to_ic[j], indexing data_from_io.
- bit [IO_WIDTH*SEL_IC + IC_WIDTH*SEL_IO + i]: mode for data_to_io[i]; 0 = combinational, 1 = registered.
REQ-022 Any select value >= its source width SHALL yield 0.
REQ-023 Mode 0: data_to_io[i] = mux output, same cycle.
REQ-024 Mode 1: data_to_io[i] = io_reg[i], which is loaded from the mux output every edge, giving one-cycle latency.
REQ-025 data_to_ic[j] SHALL always be combinational from its mux.
REQ-026 While config_active=0, SHALL force data_to_io and data_to_ic to 0; io_reg still updates from the (all-zero) active config.
REQ-027 A commit that changes mode SHALL take effect the cycle after acceptance; a registered output then shows io_reg, i.e. the previous cycle's mux output under the new config.

Reset
REQ-028 config_reset=1 SHALL, at the next edge, clear shadow, active, count, io_reg and config_active to 0.
REQ-029 Reset SHALL dominate config_enable and config_commit in the same cycle.
REQ-030 After reset: config_out=0, config_ready=0, config_active=0, data_to_io=0, data_to_ic=0.
REQ-031 Reset mid-shift SHALL discard partial config; the first commit afterwards requires a full CONFIG_WIDTH new shifts.

Verification (defaults: CONFIG_WIDTH=28, SEL_IC=3, SEL_IO=2)
REQ-032 Reset with config_enable=1 and config_in=1 -> after the edge, all outputs 0 and count 0.
REQ-033 Shift 28 ones, then 28 more cycles of config_in=0 -> config_out is 1 on cycles 29-56 and 0 afterwards; config_ready=1 after the 28th shift and stays 1, saturated.
REQ-034 Load io0 select=5, mode 0, ic0 select=2, commit:
- data_from_ic=6'b100000 -> data_to_io[0]=1 same cycle.
- Reload io0 select=7 -> data_to_io[0]=0.
- data_from_io=4'b0100 -> data_to_ic[0]=1.
REQ-035 io1 select=0, mode 1 (bit 25), commit; toggle data_from_ic[0] -> data_to_io[1] follows exactly one cycle later.
REQ-036 Commit after 27 shifts -> ignored, config_active stays 0. Shift one more bit, then commit with config_enable=1 in the same cycle -> active gets the pre-shift shadow, count=1, config_ready=0.
REQ-037 Reset asserted the cycle after a commit -> config_active and all data outputs return to 0 after the next edge.
